// File: rtl/circular_buffer_flex.sv
// circular_buffer_flex: parametrised circular FIFO for pipeline-stage lane buffering.
// Any depth >= 2 (not only powers of two), registered or first-word-fall-through read,
// occupancy count, programmable almost-full/almost-empty thresholds, flush and sticky
// overflow/underflow flags. Rejected accesses only raise a flag; they never alter contents.
module circular_buffer_flex #(
    parameter int BUFF_SIZE    = 2,
    parameter int DATA_WIDTH   = 256,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = BUFF_SIZE - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             wr_en_i,
    input  logic [DATA_WIDTH-1:0]            data_in_i,
    input  logic                             rd_en_i,
    output logic [DATA_WIDTH-1:0]            data_out_o,
    output logic                             data_valid_o,
    output logic [$clog2(BUFF_SIZE+1)-1:0]   count_o,
    output logic                             empty_o,
    output logic                             full_o,
    output logic                             almost_empty_o,
    output logic                             almost_full_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int PTR_W = $clog2(BUFF_SIZE);
    localparam int CNT_W = $clog2(BUFF_SIZE + 1);

    logic [DATA_WIDTH-1:0] mem [BUFF_SIZE];
    logic [PTR_W-1:0]      wr_pt;
    logic [PTR_W-1:0]      rd_pt;
    logic [CNT_W-1:0]      count;
    logic                  overflow_flag;
    logic                  underflow_flag;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Pointers wrap explicitly at BUFF_SIZE-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFF_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status flags all come from the registered count, so they reflect state at the edge.
    assign full           = (count == CNT_W'(BUFF_SIZE));
    assign empty          = (count == '0);
    assign wr_acc         = wr_en_i & ~full;
    assign rd_acc         = rd_en_i & ~empty;
    assign count_o        = count;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (32'(count) >= AFULL_LEVEL);
    assign almost_empty_o = (32'(count) <= AEMPTY_LEVEL);
    assign overflow_o     = overflow_flag;
    assign underflow_o    = underflow_flag;

    // Pointer, occupancy and sticky error bookkeeping; flush keeps the error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pt          <= '0;
            rd_pt          <= '0;
            count          <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else if (flush_i) begin
            wr_pt <= '0;
            rd_pt <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wr_pt <= next_ptr(wr_pt);
            if (rd_acc) rd_pt <= next_ptr(rd_pt);
            if (wr_acc && !rd_acc)
                count <= count + 1'b1;
            else if (rd_acc && !wr_acc)
                count <= count - 1'b1;
            if (wr_en_i && full)  overflow_flag  <= 1'b1;
            if (rd_en_i && empty) underflow_flag <= 1'b1;
        end
    end

    // Storage array; contents are deliberately left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && wr_acc)
            mem[wr_pt] <= data_in_i;
    end

    generate
        if (FWFT == 0) begin : g_registered
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            // Registered read port: accepted read lands one cycle later with a valid pulse.
            always_ff @(posedge clk) begin
                if (rst || flush_i) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (rd_acc) begin
                    dout_q  <= mem[rd_pt];
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign data_out_o   = dout_q;
            assign data_valid_o = valid_q;
        end else begin : g_fwft
            // Head entry is shown directly; rd_en_i pops it.
            assign data_out_o   = mem[rd_pt];
            assign data_valid_o = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_circular_buffer_flex.sv
// tb_circular_buffer_flex: directed self-checking bench for circular_buffer_flex.
// Three instances: A (depth 4, registered read), B (depth 3, registered read),
// C (depth 4, first-word-fall-through). Expected values are worked out by hand.
module tb_circular_buffer_flex;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;

    logic        wr_a = 1'b0, rd_a = 1'b0, fl_a = 1'b0;
    logic        wr_b = 1'b0, rd_b = 1'b0, fl_b = 1'b0;
    logic        wr_c = 1'b0, rd_c = 1'b0, fl_c = 1'b0;

    logic [15:0] dout_a, dout_b, dout_c;
    logic        valid_a, valid_b, valid_c;
    logic [2:0]  count_a, count_c;
    logic [1:0]  count_b;
    logic        empty_a, full_a, aempty_a, afull_a, ovf_a, unf_a;
    logic        empty_b, full_b, aempty_b, afull_b, ovf_b, unf_b;
    logic        empty_c, full_c, aempty_c, afull_c, ovf_c, unf_c;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] expData;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    circular_buffer_flex #(.BUFF_SIZE(4), .DATA_WIDTH(16), .FWFT(0)) dutA (
        .clk(clk), .rst(rst), .flush_i(fl_a), .wr_en_i(wr_a), .data_in_i(din),
        .rd_en_i(rd_a), .data_out_o(dout_a), .data_valid_o(valid_a), .count_o(count_a),
        .empty_o(empty_a), .full_o(full_a), .almost_empty_o(aempty_a),
        .almost_full_o(afull_a), .overflow_o(ovf_a), .underflow_o(unf_a)
    );

    circular_buffer_flex #(.BUFF_SIZE(3), .DATA_WIDTH(16), .FWFT(0)) dutB (
        .clk(clk), .rst(rst), .flush_i(fl_b), .wr_en_i(wr_b), .data_in_i(din),
        .rd_en_i(rd_b), .data_out_o(dout_b), .data_valid_o(valid_b), .count_o(count_b),
        .empty_o(empty_b), .full_o(full_b), .almost_empty_o(aempty_b),
        .almost_full_o(afull_b), .overflow_o(ovf_b), .underflow_o(unf_b)
    );

    circular_buffer_flex #(.BUFF_SIZE(4), .DATA_WIDTH(16), .FWFT(1)) dutC (
        .clk(clk), .rst(rst), .flush_i(fl_c), .wr_en_i(wr_c), .data_in_i(din),
        .rd_en_i(rd_c), .data_out_o(dout_c), .data_valid_o(valid_c), .count_o(count_c),
        .empty_o(empty_c), .full_o(full_c), .almost_empty_o(aempty_c),
        .almost_full_o(afull_c), .overflow_o(ovf_c), .underflow_o(unf_c)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of stimulus into the selected instance (others idle),
    // then returns just after the consuming clock edge.
    task automatic applyStimulus(input int sel, input logic wr, input logic [15:0] d,
                                 input logic rd, input logic fl);
        @(negedge clk);
        wr_a = 1'b0; rd_a = 1'b0; fl_a = 1'b0;
        wr_b = 1'b0; rd_b = 1'b0; fl_b = 1'b0;
        wr_c = 1'b0; rd_c = 1'b0; fl_c = 1'b0;
        din  = d;
        case (sel)
            0: begin wr_a = wr; rd_a = rd; fl_a = fl; end
            1: begin wr_b = wr; rd_b = rd; fl_b = fl; end
            default: begin wr_c = wr; rd_c = rd; fl_c = fl; end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count",  32'(count_a),  0);
        checkOutput("rst_empty",  32'(empty_a),  1);
        checkOutput("rst_aempty", 32'(aempty_a), 1);
        checkOutput("rst_full",   32'(full_a),   0);
        checkOutput("rst_afull",  32'(afull_a),  0);
        checkOutput("rst_valid",  32'(valid_a),  0);
        checkOutput("rst_dout",   32'(dout_a),   0);
        checkOutput("rst_ovf",    32'(ovf_a),    0);
        checkOutput("rst_unf",    32'(unf_a),    0);
        checkOutput("rst_fwft_valid", 32'(valid_c), 0);
        rst = 1'b0;

        // Write 1,2,3 then read them back with one-cycle latency.
        applyStimulus(0, 1, 16'd1, 0, 0);
        checkOutput("t1_count1",  32'(count_a),  1);
        checkOutput("t1_empty1",  32'(empty_a),  0);
        checkOutput("t1_aempty1", 32'(aempty_a), 1);
        applyStimulus(0, 1, 16'd2, 0, 0);
        checkOutput("t1_aempty2", 32'(aempty_a), 0);
        applyStimulus(0, 1, 16'd3, 0, 0);
        checkOutput("t1_count3",  32'(count_a),  3);
        checkOutput("t1_afull3",  32'(afull_a),  1);
        checkOutput("t1_full3",   32'(full_a),   0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 16'd0, 1, 0);
            checkOutput("t1_rd_data",  32'(dout_a),  32'(k));
            checkOutput("t1_rd_valid", 32'(valid_a), 1);
            checkOutput("t1_rd_count", 32'(count_a), 32'(3 - k));
        end
        checkOutput("t1_empty_end", 32'(empty_a), 1);
        applyStimulus(0, 0, 16'd0, 0, 0);
        checkOutput("t1_valid_drop", 32'(valid_a), 0);
        checkOutput("t1_dout_hold",  32'(dout_a),  3);

        // Read while empty, then simultaneous write+read while empty.
        applyStimulus(0, 0, 16'd0, 1, 0);
        checkOutput("t3_unf",   32'(unf_a),   1);
        checkOutput("t3_count", 32'(count_a), 0);
        checkOutput("t3_valid", 32'(valid_a), 0);
        applyStimulus(0, 1, 16'h55, 1, 0);
        checkOutput("t3_wr_count", 32'(count_a), 1);
        checkOutput("t3_wr_valid", 32'(valid_a), 0);
        checkOutput("t3_unf_stk",  32'(unf_a),   1);

        // Sustained write+read at count 2 across pointer wrap.
        applyStimulus(0, 1, 16'h66, 0, 0);
        checkOutput("t4_count_pre", 32'(count_a), 2);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 16'(16'h70 + k), 1, 0);
            expData = (k == 0) ? 16'h55 : (k == 1) ? 16'h66 : 16'(16'h70 + k - 2);
            checkOutput("t4_data",  32'(dout_a),  32'(expData));
            checkOutput("t4_count", 32'(count_a), 2);
            checkOutput("t4_valid", 32'(valid_a), 1);
        end

        // Fill, reject a write that collides with a read at full, then flush.
        applyStimulus(0, 1, 16'h80, 0, 0);
        checkOutput("t6_count3", 32'(count_a), 3);
        applyStimulus(0, 1, 16'h81, 0, 0);
        checkOutput("t6_full", 32'(full_a), 1);
        checkOutput("t6_ovf0", 32'(ovf_a),  0);
        applyStimulus(0, 1, 16'h82, 1, 0);
        checkOutput("t6_ovf",      32'(ovf_a),   1);
        checkOutput("t6_count_rw", 32'(count_a), 3);
        checkOutput("t6_dout_rw",  32'(dout_a),  32'h76);
        applyStimulus(0, 0, 16'd0, 0, 1);
        checkOutput("t6_fl_count", 32'(count_a), 0);
        checkOutput("t6_fl_empty", 32'(empty_a), 1);
        checkOutput("t6_fl_ovf",   32'(ovf_a),   1);
        checkOutput("t6_fl_unf",   32'(unf_a),   1);
        checkOutput("t6_fl_dout",  32'(dout_a),  0);
        checkOutput("t6_fl_valid", 32'(valid_a), 0);
        applyStimulus(0, 1, 16'h90, 0, 0);
        applyStimulus(0, 0, 16'd0, 1, 0);
        checkOutput("t6_post_fl_data", 32'(dout_a), 32'h90);
        applyStimulus(0, 1, 16'hA1, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 1, 16'hA2, 0, 0);
        rst = 1'b0;
        checkOutput("t6_rst_count",  32'(count_a),  0);
        checkOutput("t6_rst_empty",  32'(empty_a),  1);
        checkOutput("t6_rst_aempty", 32'(aempty_a), 1);
        checkOutput("t6_rst_ovf",    32'(ovf_a),    0);
        checkOutput("t6_rst_unf",    32'(unf_a),    0);
        checkOutput("t6_rst_valid",  32'(valid_a),  0);
        checkOutput("t6_rst_dout",   32'(dout_a),   0);

        // Depth-3 instance: fill, overflow, drain, then wrap.
        applyStimulus(1, 1, 16'h11, 0, 0);
        applyStimulus(1, 1, 16'h22, 0, 0);
        checkOutput("t2_afull2", 32'(afull_b), 1);
        applyStimulus(1, 1, 16'h33, 0, 0);
        checkOutput("t2_full",   32'(full_b),  1);
        checkOutput("t2_count3", 32'(count_b), 3);
        applyStimulus(1, 1, 16'h44, 0, 0);
        checkOutput("t2_ovf",       32'(ovf_b),   1);
        checkOutput("t2_count_ovf", 32'(count_b), 3);
        applyStimulus(1, 0, 16'd0, 0, 0);
        checkOutput("t2_ovf_sticky", 32'(ovf_b), 1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 0, 16'd0, 1, 0);
            checkOutput("t2_rd_data", 32'(dout_b), 32'(k * 16'h11));
        end
        checkOutput("t2_empty", 32'(empty_b), 1);
        applyStimulus(1, 1, 16'h55, 0, 0);
        applyStimulus(1, 0, 16'd0, 1, 0);
        checkOutput("t2_wrap_data", 32'(dout_b), 32'h55);
        checkOutput("t2_ovf_end",   32'(ovf_b),  1);

        // FWFT instance: head word visible without a read.
        applyStimulus(2, 1, 16'hA, 0, 0);
        checkOutput("t5_dout_a",  32'(dout_c),  32'hA);
        checkOutput("t5_valid_a", 32'(valid_c), 1);
        applyStimulus(2, 1, 16'hB, 0, 0);
        checkOutput("t5_dout_hold", 32'(dout_c),  32'hA);
        checkOutput("t5_count2",    32'(count_c), 2);
        applyStimulus(2, 0, 16'd0, 1, 0);
        checkOutput("t5_dout_b",  32'(dout_c),  32'hB);
        checkOutput("t5_valid_b", 32'(valid_c), 1);
        applyStimulus(2, 0, 16'd0, 1, 0);
        checkOutput("t5_valid_end", 32'(valid_c), 0);
        checkOutput("t5_empty_end", 32'(empty_c), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
